dac_frame_sequencer: RTL

//  Drives NUM_CH parallel-bus DAC channels (CS/WR/AB/LDAC/CLR/PD) from a valid/ready sample stream.

---
 rtl/dac_frame_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/dac_frame_sequencer.sv
// Multi-channel parallel-bus DAC write sequencer: takes one frame of NUM_CH words per
// valid/ready handshake and plays it out as CS/WR/AB/DB phases, with optional LDAC pulse.
module dac_frame_sequencer #(
    parameter int  DATA_W     = 8,
    parameter int  NUM_CH     = 2,
    parameter int  BASE_SHIFT = 5,
    parameter int  FR_W       = 3,
    parameter int  DIV_W      = 13,
    localparam int CH_W       = $clog2(NUM_CH)
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     En,
    input  logic [FR_W-1:0]          Fr,
    input  logic                     Mode,
    input  logic                     clr_req,
    input  logic                     s_valid,
    input  logic [NUM_CH*DATA_W-1:0] s_data,
    output logic                     s_ready,
    output logic [DATA_W-1:0]        DB,
    output logic                     CS,
    output logic                     WR,
    output logic [CH_W-1:0]          AB,
    output logic                     PD,
    output logic                     LDAC,
    output logic                     CLR,
    output logic                     busy,
    output logic                     frame_done
);

    typedef enum logic [2:0] {
        IDLE, SETUP, WR_LO, WR_HI, RELEASE, LOAD, CLEAR
    } state_t;

    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

    state_t                     state_reg, state_next;
    logic [DIV_W-1:0]           div_reg, div_limit;
    logic [FR_W-1:0]            fr_reg;
    logic                       mode_reg, mode_next;
    logic [NUM_CH*DATA_W-1:0]   frame_reg, frame_next;
    logic [CH_W-1:0]            ch_reg, ch_next;
    logic                       tick, accept, in_write;
    logic                       cs_next, wr_next, ldac_next, clr_next, done_next;
    logic [CH_W-1:0]            ab_next;
    logic [DATA_W-1:0]          db_next;
    logic [DATA_W-1:0]          words [NUM_CH];

    // Words are taken from frame_next so the first SETUP sees the word latched on accept.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_words
            assign words[gi] = frame_next[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign s_ready   = Rst && (state_reg == IDLE) && En && !clr_req;
    assign accept    = s_valid && s_ready;
    assign div_limit = (DIV_ONE << (BASE_SHIFT + int'(fr_reg))) - DIV_ONE;
    assign tick      = (div_reg == div_limit);
    assign busy      = (state_reg != IDLE);
    assign PD        = 1'b1;

    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        mode_next  = mode_reg;
        frame_next = frame_reg;
        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                end else if (accept) begin
                    state_next = SETUP;
                    ch_next    = '0;
                    mode_next  = Mode;
                    frame_next = s_data;
                end
            end
            SETUP:   if (tick) state_next = WR_LO;
            WR_LO:   if (tick) state_next = WR_HI;
            WR_HI:   if (tick) state_next = RELEASE;
            RELEASE: begin
                if (tick) begin
                    if (ch_reg != LAST_CH) begin
                        ch_next    = ch_reg + 1'b1;
                        state_next = SETUP;
                    end else if (mode_reg) begin
                        state_next = LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            LOAD:    if (tick) state_next = IDLE;
            CLEAR:   if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pins are decoded from the next state and registered, so they switch cleanly with the state.
    always_comb begin
        in_write  = (state_next == SETUP) || (state_next == WR_LO) || (state_next == WR_HI);
        cs_next   = !in_write;
        wr_next   = (state_next != WR_LO);
        clr_next  = (state_next != CLEAR);
        ldac_next = !((state_next == LOAD) ||
                      (!mode_next && (in_write || state_next == RELEASE)));
        done_next = (state_next == IDLE) && ((state_reg == RELEASE) || (state_reg == LOAD));
        ab_next   = AB;
        db_next   = DB;
        if ((state_next == SETUP) && (state_reg != SETUP)) begin
            ab_next = ch_next;
            db_next = words[ch_next];
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_reg  <= IDLE;
            div_reg    <= '0;
            fr_reg     <= '0;
            mode_reg   <= 1'b0;
            frame_reg  <= '0;
            ch_reg     <= '0;
            CS         <= 1'b1;
            WR         <= 1'b1;
            AB         <= '0;
            DB         <= '0;
            LDAC       <= 1'b1;
            CLR        <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ch_reg     <= ch_next;
            mode_reg   <= mode_next;
            frame_reg  <= frame_next;
            if (state_reg == IDLE) begin
                div_reg <= '0;
                if (state_next != IDLE) fr_reg <= Fr;
            end else if (tick) begin
                div_reg <= '0;
            end else begin
                div_reg <= div_reg + DIV_ONE;
            end
            CS         <= cs_next;
            WR         <= wr_next;
            AB         <= ab_next;
            DB         <= db_next;
            LDAC       <= ldac_next;
            CLR        <= clr_next;
            frame_done <= done_next;
        end
    end

endmodule
